// File: rtl/tag_ctrl.sv
// tag_ctrl: lookup/refill/flush controller for a direct-mapped cache tag store.
// Latency: a lookup handshake at edge N gives a one-cycle rsp_valid pulse after edge N+1.
// Backpressure: req_ready/fill_ready drop during LOOKUP, FLUSH and on lower-priority ports. rsp_valid has no backpressure.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   req_*              lookup request (valid/ready, index, tag)
//   rsp_valid/rsp_hit  one-cycle result pulse and hit flag (rsp_hit holds between pulses)
//   fill_*             refill write request (valid/ready, index, tag)
//   flush_*            invalidate-all request (level), sweep busy, end-of-sweep pulse
//   tr_*               tag RAM index/write enable/write data, combinational read data
//   stat_hits/misses   saturating hit/miss counters
//
// Optional build macro TAG_CTRL_STATS_EN: when defined, the hit/miss counters are built.
// When it is undefined, both stat ports are tied to 0.
module tag_ctrl #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [INDEX_W-1:0] req_index,
  input  logic [TAG_W-1:0]   req_tag,
  output logic               rsp_valid,
  output logic               rsp_hit,
  input  logic               fill_valid,
  output logic               fill_ready,
  input  logic [INDEX_W-1:0] fill_index,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic               flush_req,
  output logic               flush_busy,
  output logic               flush_done,
  output logic [INDEX_W-1:0] tr_index,
  output logic               tr_wen,
  output logic [TAG_W-1:0]   tr_wdata,
  input  logic [TAG_W-1:0]   tr_rdata,
  output logic [31:0]        stat_hits,
  output logic [31:0]        stat_misses
);

  localparam int ENTRIES = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [INDEX_W:0]   cnt_q, cnt_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_hit_q, rsp_hit_d;
  logic               flush_done_q, flush_done_d;
  logic               lookup_hit;

  // During LOOKUP tr_index is idx_q, so tr_rdata is the stored tag of the latched entry.
  // The valid bit gates the hit because the tag RAM itself is never cleared by reset.
  assign lookup_hit = valid_q[idx_q] && (tr_rdata == tag_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      tag_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_hit_q    <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      tag_q        <= tag_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_hit_q    <= rsp_hit_d;
      flush_done_q <= flush_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    tag_d        = tag_q;
    rsp_valid_d  = 1'b0;
    rsp_hit_d    = rsp_hit_q;
    flush_done_d = 1'b0;
    req_ready    = 1'b0;
    fill_ready   = 1'b0;
    tr_index     = req_index;
    tr_wen       = 1'b0;
    tr_wdata     = '0;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else if (fill_valid) begin
          fill_ready          = 1'b1;
          tr_wen              = 1'b1;
          tr_index            = fill_index;
          tr_wdata            = fill_tag;
          valid_d[fill_index] = 1'b1;
        end else begin
          req_ready = 1'b1;
          if (req_valid) begin
            idx_d   = req_index;
            tag_d   = req_tag;
            state_d = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        tr_index    = idx_q;
        rsp_valid_d = 1'b1;
        rsp_hit_d   = lookup_hit;
        state_d     = IDLE;
      end
      FLUSH: begin
        tr_index                        = cnt_q[INDEX_W-1:0];
        tr_wen                          = 1'b1;
        valid_d[cnt_q[INDEX_W-1:0]]     = 1'b0;
        cnt_d                           = cnt_q + (INDEX_W+1)'(1);
        // The extra counter bit means the sweep never wraps. The last entry ends it.
        if (cnt_q == (INDEX_W+1)'(ENTRIES-1)) begin
          state_d      = IDLE;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_hit    = rsp_hit_q;
  assign flush_done = flush_done_q;
  // flush_busy is high for each FLUSH cycle, which is exactly ENTRIES cycles.
  // Reset forces the state to IDLE, so flush_busy clears immediately.
  assign flush_busy = (state_q == FLUSH);

`ifdef TAG_CTRL_STATS_EN
  logic [31:0] hits_q, misses_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (lookup_hit) begin
        if (hits_q != 32'hFFFF_FFFF) hits_q <= hits_q + 32'd1;
      end else begin
        if (misses_q != 32'hFFFF_FFFF) misses_q <= misses_q + 32'd1;
      end
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`else
  assign stat_hits   = 32'd0;
  assign stat_misses = 32'd0;
`endif

endmodule

// File: doc/tag_ctrl.md
Name: tag_ctrl

Overview:
Lookup/refill/flush controller for a direct-mapped cache tag store. It owns the per-entry valid bits and is the only driver of the tag RAM's index, write-enable and write-data inputs. The tag RAM reads combinationally and writes on the clock edge. It arbitrates between the core lookup port, the refill port and a flush sweep, and returns hit/miss to the cache pipeline.

Parameters:
INDEX_W, 6, entry index width; ENTRIES = 2**INDEX_W
TAG_W, 20, tag width

Ports:
clk  in  1  clock, all flops rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  lookup request
req_ready  out  1  lookup accepted when req_valid && req_ready
req_index  in  INDEX_W  lookup entry
req_tag  in  TAG_W  lookup tag
rsp_valid  out  1  one-cycle result pulse
rsp_hit  out  1  hit flag, meaningful only with rsp_valid
fill_valid  in  1  refill write request
fill_ready  out  1  refill accepted
fill_index  in  INDEX_W  refill entry
fill_tag  in  TAG_W  refill tag
flush_req  in  1  invalidate-all request (level, sampled in IDLE)
flush_busy  out  1  sweep in progress
flush_done  out  1  one-cycle pulse at end of sweep
tr_index  out  INDEX_W  tag RAM index
tr_wen  out  1  tag RAM write enable
tr_wdata  out  TAG_W  tag RAM write data
tr_rdata  in  TAG_W  tag RAM read data (combinational on tr_index)
stat_hits  out  32  hit counter (optional feature)
stat_misses  out  32  miss counter (optional feature)

Behaviour:
- Reset state:
  - FSM = IDLE.
  - valid[ENTRIES-1:0] = 0.
  - Sweep counter = 0.
  - Latched index/tag = 0.
  - rsp_valid, rsp_hit, flush_busy and flush_done = 0. The stat counters = 0.
  - Tag RAM contents are not cleared; valid bits gate every hit.
- States: IDLE, LOOKUP, FLUSH.
- IDLE priority: flush_req > fill_valid > req_valid.
  - flush_req = 1: go to FLUSH. Sweep counter = 0. req_ready = fill_ready = 0.
  - Else fill_valid = 1:
    - fill_ready = 1, tr_wen = 1, tr_index = fill_index, tr_wdata = fill_tag.
    - valid[fill_index] is set at the edge. Stay in IDLE.
    - req_ready = 0 in that cycle.
  - Else req_ready = 1. On handshake, latch req_index/req_tag and go to LOOKUP.
- LOOKUP (one cycle):
  - tr_index = latched index, tr_wen = 0.
  - Hit = valid[idx] && (tr_rdata == latched tag).
  - At the edge: rsp_valid <= 1, rsp_hit <= hit, state <= IDLE.
  - req_ready = fill_ready = 0.
- Latency and throughput: handshake at edge N, rsp_valid high for exactly the cycle after edge N+1. Maximum throughput is one lookup per 2 cycles; back-to-back handshake in the rsp_valid cycle is allowed.
- rsp_valid is a pulse with no backpressure. Otherwise rsp_valid = 0 and rsp_hit holds its last value.
- FLUSH:
  - Each cycle: tr_index = counter, tr_wen = 1, tr_wdata = 0, valid[counter] <= 0, counter++.
  - flush_busy = 1 for exactly ENTRIES cycles.
  - At counter == ENTRIES-1: the edge returns to IDLE, flush_done <= 1 for one cycle, flush_busy <= 0.
  - req/fill are not accepted during FLUSH.
  - flush_req held high after completion starts a new sweep from IDLE.
- tr_wen = 0 in all cases not listed above. tr_index = req_index in IDLE when no fill is selected.
- Asynchronous reset mid-LOOKUP or mid-FLUSH: the result is dropped, all state returns to the reset values immediately, and no flush_done is issued.
- Width rules: tag comparison is full TAG_W equality. The counter is INDEX_W+1 bits internally, with no wrap inside a sweep.

Optional Feature:
- Macro: TAG_CTRL_STATS_EN.
- Defined:
  - stat_hits / stat_misses increment at the edge that produces rsp_valid, according to rsp_hit.
  - 32-bit saturating at 0xFFFFFFFF.
  - Cleared only by rst.
- Undefined: the counters are not built and both ports are tied to 0. The interface is unchanged.

Test Plan:
- After reset, lookup idx 5 tag 0x12345 -> req_ready = 1, rsp_valid pulses 2 cycles after the handshake cycle, rsp_hit = 0.
- Fill idx 5 tag 0x12345, then lookup idx 5 tag 0x12345 -> hit = 1. Then tag 0x12346 -> hit = 0. Then idx 6 tag 0x12345 -> hit = 0.
- fill_valid and req_valid asserted in the same IDLE cycle -> fill_ready = 1, req_ready = 0, tr_wen = 1. The request is accepted the next cycle, and its lookup of the same index hits.
- INDEX_W = 6 with 3 entries filled, pulse flush_req:
  - flush_busy is high 64 cycles, tr_index steps 0..63 with tr_wen = 1.
  - flush_done is a single pulse; req_ready and fill_ready stay low throughout.
  - Subsequent lookups of the filled entries -> miss.
- Assert rst while the sweep counter = 20 -> flush_busy = 0 and outputs = 0 immediately, no flush_done. After release, a previously filled entry -> miss.
- TAG_CTRL_STATS_EN defined: 3 hits and 2 misses -> stat_hits = 3, stat_misses = 2. Undefined -> both read 0.
